// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: funct3 size codes, FSM states and the
// captured-op / writeback payloads.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned F3_W   = 3;

  typedef enum logic [F3_W-1:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_D  = 3'b011,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101,
    MEM_WU = 3'b110
  } funct3_e;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_BUS  = 1'b1
  } state_e;

  typedef struct packed {
    logic              we;
    logic [F3_W-1:0]   funct3;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [NBYTES-1:0] wmask;
    logic              rf_wen;
    logic [RD_W-1:0]   rd;
    logic [XLEN-1:0]   pc;
    logic              exit;
  } op_t;

  typedef struct packed {
    logic            valid;
    logic            rf_wen;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc;
    logic            exit;
    logic            err;
  } wb_t;

  // Low address bits that must be zero for an access of size 1<<sz bytes.
  function automatic logic [OFF_W-1:0] size_lowmask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Sign or zero extend the low 1<<sz bytes of v.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0] sz,
                                             input logic sgn);
    case (sz)
      2'd0:    return {{56{sgn & v[7]}},  v[7:0]};
      2'd1:    return {{48{sgn & v[15]}}, v[15:0]};
      2'd2:    return {{32{sgn & v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane alignment for the MEM stage: store lane shift/mask, load
// extraction with extension, and misaligned/illegal-funct3 detection.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic              is_store_i,
  input  logic [F3_W-1:0]   funct3_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [NBYTES-1:0] wmask_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   ldata_o,
  output logic              misaligned_o,
  output logic              illegal_o
);

  logic [1:0]        sz;
  logic [NBYTES-1:0] base_mask;
  logic [XLEN-1:0]   rshift;

  always_comb begin
    sz = funct3_i[1:0];
    case (sz)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    wmask_o      = base_mask << off_i;
    wdata_o      = sdata_i << {off_i, 3'b000};
    rshift       = rdata_i >> {off_i, 3'b000};
    // funct3[2] selects the unsigned load variants.
    ldata_o      = extend(rshift, sz, ~funct3_i[2]);
    misaligned_o = |(off_i & size_lowmask(sz));
    illegal_o    = is_store_i ? funct3_i[2] : (funct3_i == 3'b111);
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues load/store on a req/ack data bus, stalls EX while
// pending, and registers results (or an error) toward WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [F3_W-1:0]   funct3_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic [XLEN-1:0]   aluout_i,
  input  logic              rf_wen_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              exit_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [NBYTES-1:0] mem_wmask_o,
  input  logic              mem_ack_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              valid_o,
  output logic              rf_wen_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              exit_o,
  output logic              err_o
);

  localparam int unsigned WAIT_W  = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned WD_LAST = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              req_q, req_d;
  op_t               op_q, op_d;
  wb_t               wb_q, wb_d;
  logic              stall_c;

  logic              mem_op_c;
  logic              wd_fire_c;
  logic              al_store_c;
  logic [F3_W-1:0]   al_f3_c;
  logic [OFF_W-1:0]  al_off_c;
  logic [NBYTES-1:0] al_wmask;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_ldata;
  logic              al_misaligned;
  logic              al_illegal;

  // In BUS the aligner works on the captured op; in IDLE on the incoming one.
  always_comb begin
    mem_op_c   = valid_i & (load_i | store_i);
    wd_fire_c  = (MAX_WAIT != 0) && (cnt_q == WAIT_W'(WD_LAST));
    al_store_c = (state_q == MS_BUS) ? op_q.we : store_i;
    al_f3_c    = (state_q == MS_BUS) ? op_q.funct3 : funct3_i;
    al_off_c   = (state_q == MS_BUS) ? op_q.addr[OFF_W-1:0] : aluout_i[OFF_W-1:0];
  end

  mem_stage_align u_align (
    .is_store_i   (al_store_c),
    .funct3_i     (al_f3_c),
    .off_i        (al_off_c),
    .sdata_i      (sdata_i),
    .rdata_i      (mem_rdata_i),
    .wmask_o      (al_wmask),
    .wdata_o      (al_wdata),
    .ldata_o      (al_ldata),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      op_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    op_d    = op_q;
    wb_d    = '0;
    stall_c = 1'b0;
    case (state_q)
      MS_IDLE: begin
        cnt_d = '0;
        if (valid_i) begin
          wb_d.rd   = rd_i;
          wb_d.pc   = pc_i;
          wb_d.exit = exit_i;
          if (!mem_op_c) begin
            wb_d.valid  = 1'b1;
            wb_d.rf_wen = rf_wen_i;
            wb_d.wdata  = aluout_i;
          end else if (al_illegal || al_misaligned) begin
            wb_d.valid = 1'b1;
            wb_d.err   = 1'b1;
          end else begin
            stall_c     = 1'b1;
            req_d       = 1'b1;
            state_d     = MS_BUS;
            op_d.we     = store_i;
            op_d.funct3 = funct3_i;
            op_d.addr   = aluout_i;
            op_d.wdata  = al_wdata;
            op_d.wmask  = al_wmask;
            op_d.rf_wen = rf_wen_i & ~store_i;
            op_d.rd     = rd_i;
            op_d.pc     = pc_i;
            op_d.exit   = exit_i;
          end
        end
      end
      MS_BUS: begin
        wb_d.rd   = op_q.rd;
        wb_d.pc   = op_q.pc;
        wb_d.exit = op_q.exit;
        // Ack on the watchdog cycle still completes normally.
        if (mem_ack_i) begin
          wb_d.valid  = 1'b1;
          wb_d.rf_wen = op_q.rf_wen;
          wb_d.wdata  = op_q.we ? '0 : al_ldata;
          state_d     = MS_IDLE;
          req_d       = 1'b0;
          cnt_d       = '0;
        end else if (wd_fire_c) begin
          wb_d.valid = 1'b1;
          wb_d.err   = 1'b1;
          state_d    = MS_IDLE;
          req_d      = 1'b0;
          cnt_d      = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = MS_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign stall_o     = stall_c;
  assign mem_req_o   = req_q;
  assign mem_we_o    = op_q.we;
  assign mem_addr_o  = {op_q.addr[XLEN-1:OFF_W], 3'b000};
  assign mem_wdata_o = op_q.wdata;
  assign mem_wmask_o = op_q.wmask;

  assign valid_o  = wb_q.valid;
  assign rf_wen_o = wb_q.rf_wen;
  assign rd_o     = wb_q.rd;
  assign wdata_o  = wb_q.wdata;
  assign pc_o     = wb_q.pc;
  assign exit_o   = wb_q.exit;
  assign err_o    = wb_q.err;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an arithmetic model of
// the load/store lane, extension, legality and watchdog rules.
module tb_mem_stage;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, load_i, store_i, rf_wen_i, exit_i, mem_ack_i;
  logic [2:0]  funct3_i;
  logic [63:0] sdata_i, aluout_i, pc_i, mem_rdata_i;
  logic [4:0]  rd_i;
  logic        stall_o, mem_req_o, mem_we_o, valid_o, rf_wen_o, exit_o, err_o;
  logic [63:0] mem_addr_o, mem_wdata_o, wdata_o, pc_o;
  logic [7:0]  mem_wmask_o;
  logic [4:0]  rd_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .load_i(load_i), .store_i(store_i),
    .funct3_i(funct3_i), .sdata_i(sdata_i), .aluout_i(aluout_i), .rf_wen_i(rf_wen_i),
    .rd_i(rd_i), .pc_i(pc_i), .exit_i(exit_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .valid_o(valid_o), .rf_wen_o(rf_wen_o), .rd_o(rd_o), .wdata_o(wdata_o),
    .pc_o(pc_o), .exit_o(exit_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << int'(f3 % 3'd4);
  endfunction

  // Pick n bytes starting at byte off, then sign-extend by wrapping mod 2^64.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr,
                                           input logic [63:0] rdata);
    int n;
    int off;
    logic [63:0] v;
    logic [63:0] full;
    n   = nbytes(f3);
    off = int'(addr % 64'd8);
    v   = rdata >> (8 * off);
    if (n == 8) return v;
    full = 64'd1 << (8 * n);
    v    = v % full;
    if (f3 < 3'd4 && v >= full / 64'd2) v = v - full;
    return v;
  endfunction

  function automatic logic [7:0] ref_wmask(input logic [2:0] f3, input logic [63:0] addr);
    logic [15:0] m;
    m = ((16'd1 << nbytes(f3)) - 16'd1) << int'(addr % 64'd8);
    return m[7:0];
  endfunction

  function automatic logic ref_legal(input logic st, input logic [2:0] f3);
    return st ? (f3 < 3'd4) : (f3 < 3'd7);
  endfunction

  function automatic logic ref_aligned(input logic [2:0] f3, input logic [63:0] addr);
    return (int'(addr % 64'd8) % nbytes(f3)) == 0;
  endfunction

  // Issue one op from a clean IDLE and follow it to its WB pulse.
  // ackdly: BUS cycle (1-based) in which ack arrives; > MAX_WAIT means never.
  task automatic run_op(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] rdata, input logic rfw, input logic [4:0] rd,
                        input int ackdly, input string tag);
    logic memop, ok, ack, done, timedout, eerr, erfw;
    logic [63:0] pc;
    memop    = v & (ld | st);
    ok       = memop && ref_legal(st, f3) && ref_aligned(f3, addr);
    timedout = 1'b0;
    done     = 1'b0;
    pc       = addr ^ 64'hA5A5;
    @(posedge clk); #1;
    valid_i = v; load_i = ld; store_i = st; funct3_i = f3; aluout_i = addr;
    sdata_i = sdata; rf_wen_i = rfw; rd_i = rd; pc_i = pc; exit_i = rd[0];
    mem_ack_i = 1'($urandom % 2);
    mem_rdata_i = {$urandom, $urandom};
    @(negedge clk);
    check({tag, ".stall_idle"}, 64'(stall_o), 64'(ok));
    check({tag, ".req_idle"}, 64'(mem_req_o), 64'd0);
    @(posedge clk); #1;
    if (ok) begin
      for (int k = 1; k <= int'(MAX_WAIT) && !done; k++) begin
        ack = (k == ackdly);
        mem_ack_i = ack;
        mem_rdata_i = rdata;
        @(negedge clk);
        check({tag, ".req"}, 64'(mem_req_o), 64'd1);
        check({tag, ".addr"}, mem_addr_o, {addr[63:3], 3'b000});
        check({tag, ".we"}, 64'(mem_we_o), 64'(st));
        check({tag, ".stall_bus"}, 64'(stall_o), 64'(!ack && k != int'(MAX_WAIT)));
        check({tag, ".valid_bus"}, 64'(valid_o), 64'd0);
        if (st) begin
          check({tag, ".wmask"}, 64'(mem_wmask_o), 64'(ref_wmask(f3, addr)));
          check({tag, ".wdata_bus"}, mem_wdata_o, sdata << (8 * int'(addr % 64'd8)));
        end
        @(posedge clk); #1;
        if (ack || k == int'(MAX_WAIT)) begin
          done = 1'b1;
          timedout = !ack;
        end
      end
    end
    mem_ack_i = 1'b0; valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    @(negedge clk);
    eerr = memop && (!ok || timedout);
    erfw = v && !eerr && rfw && !(memop && st);
    check({tag, ".valid"}, 64'(valid_o), 64'(v));
    check({tag, ".req_done"}, 64'(mem_req_o), 64'd0);
    if (v) begin
      check({tag, ".err"}, 64'(err_o), 64'(eerr));
      check({tag, ".rf_wen"}, 64'(rf_wen_o), 64'(erfw));
      check({tag, ".rd"}, 64'(rd_o), 64'(rd));
      check({tag, ".pc"}, pc_o, pc);
      if (!memop) check({tag, ".wdata"}, wdata_o, addr);
      else if (!eerr && ld && !st) check({tag, ".ldata"}, wdata_o, ref_load(f3, addr, rdata));
    end
  endtask

  initial begin
    int p1, p2;
    rst = 1'b1; valid_i = 0; load_i = 0; store_i = 0; funct3_i = 0; sdata_i = 0;
    aluout_i = 0; rf_wen_i = 0; rd_i = 0; pc_i = 0; exit_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.valid", 64'(valid_o), 64'd0);
    check("rst.err", 64'(err_o), 64'd0);
    check("rst.req", 64'(mem_req_o), 64'd0);
    check("rst.stall", 64'(stall_o), 64'd0);
    check("rst.wdata", wdata_o, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_op(1, 0, 0, 3'b000, 64'h1234, 0, 0, 1, 5, 1, "nonmem");
    run_op(1, 1, 0, 3'b000, 64'h1003, 0, 64'h0000_0000_8000_0000, 1, 3, 1, "lb");
    run_op(1, 1, 0, 3'b100, 64'h1003, 0, 64'h0000_0000_8000_0000, 1, 3, 1, "lbu");
    run_op(1, 0, 1, 3'b001, 64'h2006, 64'hBEEF, 0, 1, 4, 3, "sh");
    run_op(1, 1, 0, 3'b010, 64'h3002, 0, 0, 1, 6, 1, "lw_mis");
    run_op(1, 0, 1, 3'b100, 64'h3000, 64'h55, 0, 1, 6, 1, "sb_ill");
    run_op(1, 1, 0, 3'b011, 64'h5000, 0, 64'h1122_3344_5566_7788, 1, 9, 99, "wd_abort");
    run_op(1, 1, 0, 3'b011, 64'h5000, 0, 64'h1122_3344_5566_7788, 1, 9, 4, "wd_ack");
    run_op(0, 1, 0, 3'b011, 64'h5000, 0, 0, 1, 9, 1, "bubble");

    // Reset in BUS, with ack present: reset wins.
    @(posedge clk); #1;
    valid_i = 1; load_i = 1; store_i = 0; funct3_i = 3'b011; aluout_i = 64'h6000; rd_i = 2;
    @(posedge clk); #1;
    rst = 1; mem_ack_i = 1; mem_rdata_i = 64'hDEAD;
    @(negedge clk);
    check("rstbus.req_before", 64'(mem_req_o), 64'd1);
    @(posedge clk); #1;
    rst = 0; mem_ack_i = 0; valid_i = 0; load_i = 0;
    @(negedge clk);
    check("rstbus.req", 64'(mem_req_o), 64'd0);
    check("rstbus.valid", 64'(valid_o), 64'd0);
    check("rstbus.err", 64'(err_o), 64'd0);
    check("rstbus.stall", 64'(stall_o), 64'd0);

    // Back-to-back LD, LD each acked in its first BUS cycle.
    @(posedge clk); #1;
    valid_i = 1; load_i = 1; funct3_i = 3'b011; aluout_i = 64'h4000; rd_i = 7; rf_wen_i = 1;
    @(posedge clk); #1;
    mem_ack_i = 1; mem_rdata_i = 64'hAAAA_0000_BBBB_1111;
    @(negedge clk);
    check("b2b.stall1", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    aluout_i = 64'h4008; rd_i = 8; mem_ack_i = 0;
    @(negedge clk);
    check("b2b.valid1", 64'(valid_o), 64'd1);
    check("b2b.data1", wdata_o, 64'hAAAA_0000_BBBB_1111);
    p1 = cyc;
    @(posedge clk); #1;
    mem_ack_i = 1; mem_rdata_i = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    check("b2b.valid_gap", 64'(valid_o), 64'd0);
    @(posedge clk); #1;
    valid_i = 0; load_i = 0; mem_ack_i = 0;
    @(negedge clk);
    check("b2b.valid2", 64'(valid_o), 64'd1);
    check("b2b.data2", wdata_o, 64'h0123_4567_89AB_CDEF);
    check("b2b.rd2", 64'(rd_o), 64'd8);
    p2 = cyc;
    check("b2b.spacing", 64'(p2 - p1), 64'd2);

    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [63:0] a;
      kind = int'($urandom % 4);
      a = {$urandom, $urandom};
      if ($urandom % 2 == 0) a[2:0] = 3'b000;
      run_op(kind != 3, kind == 1, kind == 2, 3'($urandom % 8), a, {$urandom, $urandom},
             {$urandom, $urandom}, 1'($urandom % 2), 5'($urandom % 32),
             int'($urandom_range(1, 5)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
